// File: rtl/w_74hc161_updown_counter_pkg.sv
// Shared constants and helpers for the 74HC161/191-style up/down counter.
// Holds direction encodings, default WIDTH/MOD values and the TOP calculation.
package w_74hc161_updown_counter_pkg;

  localparam logic W74_UP = 1'b1;
  localparam logic W74_DN = 1'b0;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_MOD   = 10;

  // Terminal count: MOD-1 in modulo mode, all-ones in binary mode.
  function automatic int top_value(input int width, input int mod, input bit mod_en);
    if (mod_en) return mod - 1;
    else        return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/w_74hc161_next.sv
// Combinational next-count value for the up/down counter, given the current
// state, direction and terminal count. Load/enable priority lives in the top.
module w_74hc161_next
  import w_74hc161_updown_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] top_i,
  output logic [WIDTH-1:0] q_next_o
);

  // Up uses >= so an out-of-range value above TOP recovers to 0 in one count;
  // down from above TOP simply decrements.
  always_comb begin
    q_next_o = q_i;
    if (up_i == W74_UP) begin
      if (q_i >= top_i) q_next_o = '0;
      else              q_next_o = q_i + 1'b1;
    end else begin
      if (q_i == '0)    q_next_o = top_i;
      else              q_next_o = q_i - 1'b1;
    end
  end

endmodule

// File: rtl/w_74hc161_updown_counter.sv
// Presettable, cascadable up/down counter (74HC161/191 style) with async clear.
// Define W_74HC161_MOD_EN to build a modulo-MOD counter instead of full binary.
module w_74hc161_updown_counter
  import w_74hc161_updown_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MOD   = DEF_MOD
) (
  input  logic             clk,
  input  logic             r,
  input  logic             ld_n,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco
);

`ifdef W_74HC161_MOD_EN
  localparam bit MOD_EN = 1'b1;
`else
  localparam bit MOD_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] TOP = WIDTH'(top_value(WIDTH, MOD, MOD_EN));

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  w_74hc161_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .q_i     (q_q),
    .up_i    (up),
    .top_i   (TOP),
    .q_next_o(q_d)
  );

  // Priority: clear > load > count (enp & ent) > hold.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      q_q <= '0;
    end else if (!ld_n) begin
      q_q <= d;
    end else if (enp && ent) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

  // No enp term: a cascaded stage sees the carry even while counting is paused.
  assign rco = ent & ((up == W74_UP) ? (q_q == TOP) : (q_q == '0));

endmodule

// File: tb/tb_w_74hc161_updown_counter.sv
// Directed + randomized bench for w_74hc161_updown_counter, compared against a
// behavioural model built from the counting rules; also checks an 8-bit cascade.
module tb_w_74hc161_updown_counter;

  localparam int W   = 4;
  localparam int MOD = 10;
`ifdef W_74HC161_MOD_EN
  localparam int TOP = MOD - 1;
`else
  localparam int TOP = (1 << W) - 1;
`endif

  logic         clk = 1'b0;
  logic         r = 1'b0;
  logic         ld_n = 1'b1;
  logic         enp = 1'b0;
  logic         ent = 1'b1;
  logic         up = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic         rco;

  logic         ld_c = 1'b1;
  logic         enp_c = 1'b0;
  logic [7:0]   d8 = '0;
  logic [W-1:0] q_lo, q_hi;
  logic         rco_lo, rco_hi;

  int checks = 0;
  int errors = 0;
  int mq = 0;
  int m8 = 0;

  always #33 clk = ~clk;

  w_74hc161_updown_counter #(.WIDTH(W), .MOD(MOD)) dut (
    .clk(clk), .r(r), .ld_n(ld_n), .enp(enp), .ent(ent), .up(up),
    .d(d), .q(q), .rco(rco)
  );

  w_74hc161_updown_counter #(.WIDTH(W), .MOD(MOD)) u_lo (
    .clk(clk), .r(r), .ld_n(ld_c), .enp(enp_c), .ent(1'b1), .up(1'b1),
    .d(d8[3:0]), .q(q_lo), .rco(rco_lo)
  );

  w_74hc161_updown_counter #(.WIDTH(W), .MOD(MOD)) u_hi (
    .clk(clk), .r(r), .ld_n(ld_c), .enp(enp_c), .ent(rco_lo), .up(1'b1),
    .d(d8[7:4]), .q(q_hi), .rco(rco_hi)
  );

  function automatic int step_val(input int cur, input bit dir_up);
    if (dir_up) return (cur >= TOP) ? 0 : cur + 1;
    else        return (cur == 0) ? TOP : cur - 1;
  endfunction

  function automatic bit exp_rco(input int cur, input bit t, input bit dir_up);
    return t && (dir_up ? (cur == TOP) : (cur == 0));
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_main(input string tag);
    check({tag, "_q"}, 8'(q), 8'(mq));
    check({tag, "_rco"}, 8'(rco), 8'(exp_rco(mq, ent, up)));
  endtask

  // One rising edge: apply the model with the inputs held across the edge, then sample.
  task automatic tick();
    @(posedge clk);
    if (!r)            mq = 0;
    else if (!ld_n)    mq = int'(d);
    else if (enp && ent) mq = step_val(mq, up);
    if (!r)            m8 = 0;
    else if (!ld_c)    m8 = int'(d8);
    else if (enp_c)    m8 = (m8 + 1) % 256;
    #1;
  endtask

  task automatic load(input int v);
    ld_n = 1'b0; d = W'(v);
    tick();
    ld_n = 1'b1;
  endtask

  initial begin
    // Reset state: q=0, rco = ent & ~up
    #5;
    check_main("reset");
    r = 1'b1;
    tick();

    // 1. Async clear mid-cycle
    load(9);
    check_main("load9");
    #10 r = 1'b0; mq = 0;
    #1 check("async_clr_q", 8'(q), 8'h0);
    enp = 1'b1; ent = 1'b1; up = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_main("held_reset");
    end
    #5 r = 1'b1;
    tick();
    check_main("first_after_reset");

    // 2. Load beats count, then count up through wrap
    ld_n = 1'b0; d = 4'hC;
    tick();
    ld_n = 1'b1;
    check_main("load_beats_count");
    for (int i = 0; i < 5; i++) begin
      tick();
      check_main("count_up");
    end

    // 3. Count down through 0, then hold on enp=0 and ent=0
    load(1);
    up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_main("count_down");
    end
    enp = 1'b0;
    tick();
    check_main("hold_enp0");
    ent = 1'b0;
    tick();
    check_main("hold_ent0");
    ent = 1'b1; enp = 1'b1;

    // 6. Direction toggling every cycle from 5
    load(5);
    for (int i = 0; i < 4; i++) begin
      up = (i % 2 == 0);
      tick();
      check_main("toggle_dir");
    end

`ifdef W_74HC161_MOD_EN
    // 5. Modulo count and out-of-range recovery
    up = 1'b1;
    load(0);
    for (int i = 0; i < 11; i++) begin
      tick();
      check_main("mod_up");
    end
    load(13);
    tick();
    check_main("mod_recover");
    load(0);
    up = 1'b0;
    tick();
    check_main("mod_down_wrap");
`else
    // 4. 8-bit cascade from FE
    ld_c = 1'b0; d8 = 8'hFE;
    tick();
    ld_c = 1'b1; enp_c = 1'b1;
    check("casc_load", {q_hi, q_lo}, 8'(m8));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("casc_q", {q_hi, q_lo}, 8'(m8));
      check("casc_rco_hi", 8'(rco_hi), 8'(m8 == 255));
    end
    enp_c = 1'b0;
`endif

    // Randomized phase
    for (int i = 0; i < 300; i++) begin
      ld_n = ($urandom_range(0, 7) != 0);
      enp  = ($urandom_range(0, 3) != 0);
      ent  = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom_range(0, 1));
      d    = W'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 24) == 0) begin
        r = 1'b0; mq = 0; m8 = 0;
        #1 check_main("rand_async_clr");
      end else begin
        r = 1'b1;
      end
      tick();
      check_main("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
